// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the multiply/divide sequencer.
// Holds the op encoding, default latencies, the result payload struct and
// op-classification helpers. The multiply-accumulate ops are legal only
// when MD_MADD_EN is defined.
package md_pkg;

  localparam int unsigned MD_DATA_W          = 32;
  localparam int unsigned MD_OP_W            = 4;
  localparam int unsigned MD_MULT_CYCLES_DEF = 5;
  localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

  typedef enum logic [MD_OP_W-1:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MADD  = 4'd7,
    MD_MADDU = 4'd8,
    MD_MSUB  = 4'd9,
    MD_MSUBU = 4'd10
  } md_op_e;

  // New HI/LO pair plus a write enable (cleared for divide by zero).
  typedef struct packed {
    logic [MD_DATA_W-1:0] hi;
    logic [MD_DATA_W-1:0] lo;
    logic                 we;
  } md_result_t;

  // Ops that occupy the unit for a multi-cycle latency.
  function automatic logic md_is_long(input logic [MD_OP_W-1:0] op);
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU,
      MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: return 1'b1;
      default:                              return 1'b0;
    endcase
  endfunction

  function automatic logic md_is_div(input logic [MD_OP_W-1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Ops that are accepted at all; everything else behaves as MD_NONE.
  function automatic logic md_is_legal(input logic [MD_OP_W-1:0] op);
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO: return 1'b1;
`ifdef MD_MADD_EN
      MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU:                 return 1'b1;
`endif
      default:                                              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/md_compute.sv
// md_compute: combinational result generator for md_ctrl.
// Ports:
//   i_op         operation code (md_pkg encoding)
//   i_a, i_b     rs / rt operands
//   i_hi, i_lo   current architectural HI/LO (accumulate base, pass-through)
//   o_res_c      new {hi, lo} and write enable
// Multiply-accumulate ops are decoded only when MD_MADD_EN is defined.
module md_compute
  import md_pkg::*;
(
  input  logic [MD_OP_W-1:0]   i_op,
  input  logic [MD_DATA_W-1:0] i_a,
  input  logic [MD_DATA_W-1:0] i_b,
  input  logic [MD_DATA_W-1:0] i_hi,
  input  logic [MD_DATA_W-1:0] i_lo,
  output md_result_t           o_res_c
);

  localparam int unsigned PW = 2 * MD_DATA_W;

  logic [PW-1:0] w_a_sx, w_b_sx, w_a_zx, w_b_zx;
  logic [PW-1:0] w_prod_s, w_prod_u;
  logic signed [MD_DATA_W-1:0] w_as, w_bs, w_q_s, w_r_s;
  logic [MD_DATA_W-1:0] w_q_u, w_r_u;
  logic w_b_zero, w_div_ovf;

  // Low 64 bits of a product of sign-extended operands equal the signed product.
  assign w_a_sx   = {{MD_DATA_W{i_a[MD_DATA_W-1]}}, i_a};
  assign w_b_sx   = {{MD_DATA_W{i_b[MD_DATA_W-1]}}, i_b};
  assign w_a_zx   = {{MD_DATA_W{1'b0}}, i_a};
  assign w_b_zx   = {{MD_DATA_W{1'b0}}, i_b};
  assign w_prod_s = w_a_sx * w_b_sx;
  assign w_prod_u = w_a_zx * w_b_zx;

  assign w_as  = $signed(i_a);
  assign w_bs  = $signed(i_b);
  assign w_q_s = w_as / w_bs;
  assign w_r_s = w_as % w_bs;
  assign w_q_u = i_a / i_b;
  assign w_r_u = i_a % i_b;

  assign w_b_zero  = (i_b == '0);
  // Most-negative / -1 overflows the quotient; wrap instead of trapping.
  assign w_div_ovf = (i_a == {1'b1, {(MD_DATA_W-1){1'b0}}}) && (i_b == '1);

`ifdef MD_MADD_EN
  logic [PW-1:0] w_acc;
  assign w_acc = {i_hi, i_lo};
`endif

  // Result select; HI/LO pass through for anything that does not write them.
  always_comb begin
    o_res_c.hi = i_hi;
    o_res_c.lo = i_lo;
    o_res_c.we = 1'b0;
    case (i_op)
      MD_MULT: begin
        {o_res_c.hi, o_res_c.lo} = w_prod_s;
        o_res_c.we = 1'b1;
      end
      MD_MULTU: begin
        {o_res_c.hi, o_res_c.lo} = w_prod_u;
        o_res_c.we = 1'b1;
      end
      MD_DIV: begin
        if (!w_b_zero) begin
          o_res_c.we = 1'b1;
          if (w_div_ovf) begin
            o_res_c.hi = '0;
            o_res_c.lo = i_a;
          end else begin
            o_res_c.hi = w_r_s;
            o_res_c.lo = w_q_s;
          end
        end
      end
      MD_DIVU: begin
        if (!w_b_zero) begin
          o_res_c.we = 1'b1;
          o_res_c.hi = w_r_u;
          o_res_c.lo = w_q_u;
        end
      end
      MD_MTHI: begin
        o_res_c.hi = i_a;
        o_res_c.we = 1'b1;
      end
      MD_MTLO: begin
        o_res_c.lo = i_a;
        o_res_c.we = 1'b1;
      end
`ifdef MD_MADD_EN
      MD_MADD: begin
        {o_res_c.hi, o_res_c.lo} = w_acc + w_prod_s;
        o_res_c.we = 1'b1;
      end
      MD_MADDU: begin
        {o_res_c.hi, o_res_c.lo} = w_acc + w_prod_u;
        o_res_c.we = 1'b1;
      end
      MD_MSUB: begin
        {o_res_c.hi, o_res_c.lo} = w_acc - w_prod_s;
        o_res_c.we = 1'b1;
      end
      MD_MSUBU: begin
        {o_res_c.hi, o_res_c.lo} = w_acc - w_prod_u;
        o_res_c.we = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/md_ctrl.sv
// md_ctrl: multiply/divide sequencer owning HI/LO beside the E-stage ALU.
// Ports:
//   clk, reset   clock; asynchronous active-low reset
//   start, op    E-stage op valid + code
//   a, b         forwarded rs / rt operands
//   md_use_d     D-stage instruction touches HI/LO or the md unit
//   busy         result pending
//   stall_req    combinational stall request to the hazard unit
//   hi, lo       architectural HI/LO
// Parameters MULT_CYCLES / DIV_CYCLES (both >= 1) set the busy latency.
// Define MD_MADD_EN to enable madd/maddu/msub/msubu.
module md_ctrl
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [MD_OP_W-1:0]   op,
  input  logic [MD_DATA_W-1:0] a,
  input  logic [MD_DATA_W-1:0] b,
  input  logic                 md_use_d,
  output logic                 busy,
  output logic                 stall_req,
  output logic [MD_DATA_W-1:0] hi,
  output logic [MD_DATA_W-1:0] lo
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;

  state_e             r_state, w_state_n;
  logic [CNT_W-1:0]   r_cnt, w_cnt_n;
  md_result_t         r_pend, w_pend_n;
  logic [MD_DATA_W-1:0] r_hi, r_lo, w_hi_n, w_lo_n;
  md_result_t         w_res;
  logic               w_accept;

  md_compute u_compute (
    .i_op    (op),
    .i_a     (a),
    .i_b     (b),
    .i_hi    (r_hi),
    .i_lo    (r_lo),
    .o_res_c (w_res)
  );

  assign w_accept  = start & (r_state == ST_IDLE) & md_is_legal(op);
  assign busy      = (r_state == ST_RUN);
  assign stall_req = md_use_d & (busy | w_accept);
  assign hi        = r_hi;
  assign lo        = r_lo;

  // State, countdown, pending result and architectural HI/LO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_pend  <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_pend  <= w_pend_n;
      r_hi    <= w_hi_n;
      r_lo    <= w_lo_n;
    end
  end

  // Accept, count down, commit on the last busy edge.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_pend_n  = r_pend;
    w_hi_n    = r_hi;
    w_lo_n    = r_lo;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (md_is_long(op)) begin
            w_state_n = ST_RUN;
            w_cnt_n   = md_is_div(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            w_pend_n  = w_res;
          end else if (w_res.we) begin
            // mthi/mtlo write straight through without occupying the unit.
            w_hi_n = w_res.hi;
            w_lo_n = w_res.lo;
          end
        end
      end
      ST_RUN: begin
        w_cnt_n = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_state_n = ST_IDLE;
          if (r_pend.we) begin
            w_hi_n = r_pend.hi;
            w_lo_n = r_pend.lo;
          end
        end
      end
      default: begin
        w_state_n = ST_IDLE;
        w_cnt_n   = '0;
      end
    endcase
  end

  // A legal op issued while busy is dropped; the hazard unit should have stalled it.
  a_no_start_while_busy: assert property (
    @(posedge clk) disable iff (!reset) !(start && busy && md_is_legal(op))
  ) else $warning("md_ctrl: op issued while busy was ignored (hazard unit did not stall)");

endmodule

// File: tb/tb_md_ctrl.sv
// tb_md_ctrl: self-checking bench for md_ctrl with a cycle-level
// behavioural model (absolute accept cycle + 64-bit arithmetic).
module tb_md_ctrl;
  import md_pkg::*;

  localparam int unsigned MULT_N = 5;
  localparam int unsigned DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset, start, md_use_d;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        busy, stall_req;
  logic [31:0] hi, lo;

  md_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .md_use_d(md_use_d), .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Model state
  logic [31:0] m_hi, m_lo, m_rhi, m_rlo;
  bit          m_active, m_rwe;
  int          m_acc, m_n;

  // Expected outputs for the current cycle
  bit          chk_en = 1'b0;
  logic        e_busy, e_stall;
  logic [31:0] e_hi, e_lo;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [3:0] o);
    if (o >= 4'd1 && o <= 4'd6) return 1'b1;
`ifdef MD_MADD_EN
    if (o >= 4'd7 && o <= 4'd10) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic bit m_is_busy(input int c);
    return m_active && (c > m_acc) && (c <= m_acc + m_n);
  endfunction

  // Architectural effect of an op: new {hi,lo}, write flag, latency (0 = immediate).
  task automatic exec(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] chi, input logic [31:0] clo,
                      output bit we, output logic [31:0] nhi, output logic [31:0] nlo,
                      output int n);
    int ix, iy;
    longint sx, sy, q, r;
    longint unsigned ux, uy;
    logic [63:0] acc;
    ix = x; iy = y;
    sx = ix; sy = iy;
    ux = {32'h0, x}; uy = {32'h0, y};
    acc = {chi, clo};
    we = 1'b1; nhi = chi; nlo = clo; n = 0;
    case (o)
      4'd1: begin {nhi, nlo} = 64'(sx * sy); n = MULT_N; end
      4'd2: begin {nhi, nlo} = 64'(ux * uy); n = MULT_N; end
      4'd3: begin
        n = DIV_N;
        if (y == 32'h0) we = 1'b0;
        else begin q = sx / sy; r = sx % sy; nlo = 32'(q); nhi = 32'(r); end
      end
      4'd4: begin
        n = DIV_N;
        if (y == 32'h0) we = 1'b0;
        else begin nlo = x / y; nhi = x % y; end
      end
      4'd5: nhi = x;
      4'd6: nlo = x;
      4'd7:  begin {nhi, nlo} = acc + 64'(sx * sy); n = MULT_N; end
      4'd8:  begin {nhi, nlo} = acc + 64'(ux * uy); n = MULT_N; end
      4'd9:  begin {nhi, nlo} = acc - 64'(sx * sy); n = MULT_N; end
      4'd10: begin {nhi, nlo} = acc - 64'(ux * uy); n = MULT_N; end
      default: we = 1'b0;
    endcase
  endtask

  // One clock cycle: drive inputs, publish expectations, advance the model.
  task automatic step(input bit s, input logic [3:0] o, input logic [31:0] x,
                      input logic [31:0] y, input bit u);
    bit acc, we;
    logic [31:0] nhi, nlo;
    int n;
    start = s; op = o; a = x; b = y; md_use_d = u;
    e_busy  = m_is_busy(cyc);
    e_hi    = m_hi;
    e_lo    = m_lo;
    acc     = s && !e_busy && legal(o);
    e_stall = u && (e_busy || acc);
    chk_en  = 1'b1;
    exec(o, x, y, m_hi, m_lo, we, nhi, nlo, n);
    @(posedge clk);
    if (m_active && cyc == m_acc + m_n) begin
      if (m_rwe) begin m_hi = m_rhi; m_lo = m_rlo; end
      m_active = 1'b0;
    end
    if (acc) begin
      if (n > 0) begin
        m_active = 1'b1; m_acc = cyc; m_n = n;
        m_rhi = nhi; m_rlo = nlo; m_rwe = we;
      end else if (we) begin
        m_hi = nhi; m_lo = nlo;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic wait_free(input bit u, output int nb);
    nb = 0;
    while (busy === 1'b1 && nb < 64) begin
      step(1'b0, 4'd0, 32'h0, 32'h0, u);
      nb++;
    end
    if (nb >= 64) chk("wait_free_timeout", 32'(nb), 32'd63);
  endtask

  // Assert reset between edges, check the asynchronous clear, release a cycle later.
  task automatic do_reset();
    chk_en = 1'b0;
    start = 1'b0; op = 4'd0; md_use_d = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    m_hi = 32'h0; m_lo = 32'h0; m_active = 1'b0;
    @(posedge clk);
    cyc++;
    #1;
    reset = 1'b1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(e_busy));
      chk("stall_req", 32'(stall_req), 32'(e_stall));
      chk("hi", hi, e_hi);
      chk("lo", lo, e_lo);
    end
  end

  initial begin
    int nb;
    logic [3:0] o;
    reset = 1'b0; start = 1'b0; op = 4'd0; a = '0; b = '0; md_use_d = 1'b0;
    m_hi = '0; m_lo = '0; m_rhi = '0; m_rlo = '0;
    m_active = 1'b0; m_rwe = 1'b0; m_acc = 0; m_n = 0;
    e_busy = 1'b0; e_stall = 1'b0; e_hi = '0; e_lo = '0;

    repeat (2) @(posedge clk);
    #1;
    md_use_d = 1'b1;
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_stall", 32'(stall_req), 32'd0);
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    md_use_d = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;

    // mult / multu
    step(1'b1, MD_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0);
    wait_free(1'b0, nb);
    chk("mult_latency", 32'(nb), 32'd5);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFE);
    step(1'b1, MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
    wait_free(1'b0, nb);
    chk("multu_hi", hi, 32'h1);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    // div / divu by zero / overflow
    step(1'b1, MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_free(1'b0, nb);
    chk("div_latency", 32'(nb), 32'd10);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    step(1'b1, MD_DIVU, 32'd7, 32'd0, 1'b0);
    wait_free(1'b0, nb);
    chk("divz_latency", 32'(nb), 32'd10);
    chk("divz_hi", hi, 32'hFFFF_FFFF);
    chk("divz_lo", lo, 32'hFFFF_FFFD);
    step(1'b1, MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_free(1'b0, nb);
    chk("divovf_lo", lo, 32'h8000_0000);
    chk("divovf_hi", hi, 32'h0);

    // mthi while idle
    step(1'b1, MD_MTHI, 32'h1234, 32'h0, 1'b0);
    chk("mthi_hi", hi, 32'h1234);
    chk("mthi_busy", 32'(busy), 32'd0);
    chk("mthi_lo", lo, 32'h8000_0000);

    // stall window with an ignored mtlo at T+3
    step(1'b1, MD_MULT, 32'd3, 32'd4, 1'b1);
    step(1'b0, MD_NONE, 32'h0, 32'h0, 1'b1);
    step(1'b0, MD_NONE, 32'h0, 32'h0, 1'b1);
    step(1'b1, MD_MTLO, 32'hDEAD, 32'h0, 1'b1);
    wait_free(1'b1, nb);
    chk("stall_tail", 32'(nb), 32'd2);
    chk("stall_t6", 32'(stall_req), 32'd0);
    chk("stall_hi", hi, 32'h0);
    chk("stall_lo", lo, 32'd12);
    step(1'b0, MD_NONE, 32'h0, 32'h0, 1'b1);

    // madd with hi=0, lo=0xFFFFFFFF
    step(1'b1, MD_MTLO, 32'hFFFF_FFFF, 32'h0, 1'b0);
    step(1'b1, MD_MADD, 32'd1, 32'd1, 1'b0);
`ifdef MD_MADD_EN
    wait_free(1'b0, nb);
    chk("madd_hi", hi, 32'h1);
    chk("madd_lo", lo, 32'h0);
`else
    chk("madd_off_busy", 32'(busy), 32'd0);
    chk("madd_off_hi", hi, 32'h0);
    chk("madd_off_lo", lo, 32'hFFFF_FFFF);
`endif

    // reset mid-RUN, then a fresh mult right after release
    step(1'b1, MD_MULT, 32'd5, 32'd6, 1'b0);
    step(1'b0, MD_NONE, 32'h0, 32'h0, 1'b0);
    do_reset();
    step(1'b1, MD_MULT, 32'd7, 32'd8, 1'b0);
    chk("post_rst_busy", 32'(busy), 32'd1);
    wait_free(1'b0, nb);
    chk("post_rst_lo", lo, 32'd56);
    chk("post_rst_hi", hi, 32'h0);

    // randomized traffic; while busy only non-legal codes are issued
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        if (m_is_busy(cyc))
          o = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(11, 15));
        else
          o = 4'($urandom_range(0, 15));
        step($urandom_range(0, 2) == 0, o, pick(), pick(), 1'($urandom_range(0, 1)));
      end
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
